// File: rtl/mult_seq_core.sv
// Sequential signed multiplier: parity-checked operand capture, then a
// magnitude shift-add over WIDTH cycles with the sign applied on entry to DONE.
module mult_seq_core #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [WIDTH-1:0]   arg_a,
    input  logic               arg_a_parity,
    input  logic [WIDTH-1:0]   arg_b,
    input  logic               arg_b_parity,
    output logic               ack,
    output logic [2*WIDTH-1:0] result,
    output logic               result_parity,
    output logic               result_rdy,
    output logic               arg_parity_error
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic            neg_q, neg_d;
    logic            perr_q, perr_d;
    logic            ack_q, ack_d;
    logic            rdy_q, rdy_d;
    logic [RW-1:0]   res_q, res_d;
    logic            rpar_q, rpar_d;
    logic            aperr_q, aperr_d;

    logic             a_bad, b_bad;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [RW-1:0]    acc_sum;

    // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
    always_comb begin
        a_bad = ^{arg_a, arg_a_parity};
        b_bad = ^{arg_b, arg_b_parity};
        mag_a = arg_a[WIDTH-1] ? (~arg_a + WIDTH'(1)) : arg_a;
        mag_b = arg_b[WIDTH-1] ? (~arg_b + WIDTH'(1)) : arg_b;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        perr_d   = perr_q;
        ack_d    = 1'b0;
        rdy_d    = 1'b0;
        res_d    = res_q;
        rpar_d   = rpar_q;
        aperr_d  = aperr_q;
        acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    ack_d    = 1'b1;
                    mcand_d  = RW'(mag_a);
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = arg_a[WIDTH-1] ^ arg_b[WIDTH-1];
                    perr_d   = a_bad | b_bad;
                    state_d  = (a_bad | b_bad) ? DONE : MUL;
                end
            end
            MUL: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    // Negating zero wraps back to zero, so a zero product stays +0.
                    acc_d   = neg_q ? (~acc_sum + RW'(1)) : acc_sum;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    acc_d = acc_sum;
                end
            end
            DONE: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
                if (perr_q) begin
                    res_d   = '0;
                    rpar_d  = 1'b0;
                    aperr_d = 1'b1;
                end else begin
                    res_d   = acc_q;
                    rpar_d  = ^acc_q;
                    aperr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            perr_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdy_q    <= 1'b0;
            res_q    <= '0;
            rpar_q   <= 1'b0;
            aperr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            perr_q   <= perr_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
            res_q    <= res_d;
            rpar_q   <= rpar_d;
            aperr_q  <= aperr_d;
        end
    end

    assign ack              = ack_q;
    assign result_rdy       = rdy_q;
    assign result           = res_q;
    assign result_parity    = rpar_q;
    assign arg_parity_error = aperr_q;

endmodule
